// File: rtl/audio_pkg.sv
// Shared audio-path definitions: sample width, receiver FSM encoding and the
// saturating counter helper used by the I2S receiver.
package audio_pkg;

    localparam int AUDIO_W   = 24;
    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        WAIT_LR = 2'd0,
        SKIP    = 2'd1,
        SHIFT   = 2'd2,
        HOLD    = 2'd3
    } rx_state_t;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchronizer with rising-edge detect on the clock-like input `d`,
// plus an equal-depth chain (no edge detect) for side signals that must stay aligned with it.
module sync_rise #(
    parameter int STAGES = 2,
    parameter int AUX_W  = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             d,
    input  logic [AUX_W-1:0] aux,
    output logic             rise,
    output logic [AUX_W-1:0] aux_q
);

    logic [STAGES-1:0]            d_sync;
    logic [STAGES-1:0][AUX_W-1:0] aux_sync;
    logic                         d_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_sync   <= '0;
            aux_sync <= '0;
            d_hist   <= 1'b0;
        end else begin
            d_sync   <= {d_sync[STAGES-2:0], d};
            aux_sync <= {aux_sync[STAGES-2:0], aux};
            d_hist   <= d_sync[STAGES-1];
        end
    end

    assign rise  = d_sync[STAGES-1] & ~d_hist;
    assign aux_q = aux_sync[STAGES-1];

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: oversamples bclk/lrclk/sdata in the clk domain and emits
// paired 24-bit L/R samples with a one-cycle valid. Option: I2S_RX_ERR_CNT_EN adds err_cnt.
module i2s_adc_rx
    import audio_pkg::*;
#(
    parameter int W           = AUDIO_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ac_bclk,
    input  logic                 ac_lrclk,
    input  logic                 ac_adc_sdata,
    output logic [W-1:0]         l_data,
    output logic [W-1:0]         r_data,
    output logic                 valid,
`ifdef I2S_RX_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(W);

    logic             tick;
    logic [1:0]       aux_s;
    logic             lr_s;
    logic             sdata_s;

    rx_state_t        state;
    logic             lr_prev;
    logic             lr_primed;
    logic             chan;
    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [W-1:0]     l_hold;
    logic             left_ok;

    logic             lr_chg;
    logic             last_bit;
    logic             short_evt;
    logic [W-1:0]     word;

    sync_rise #(
        .STAGES (SYNC_STAGES),
        .AUX_W  (2)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (ac_bclk),
        .aux     ({ac_adc_sdata, ac_lrclk}),
        .rise    (tick),
        .aux_q   (aux_s)
    );

    assign lr_s    = aux_s[0];
    assign sdata_s = aux_s[1];

    // The first tick after reset only records lrclk, so no edge is invented from the reset value.
    assign lr_chg    = lr_primed & (lr_s ^ lr_prev);
    assign last_bit  = (bit_cnt == CNT_W'(W-1));
    assign short_evt = tick & (state == SHIFT) & lr_chg & ~last_bit;
    assign word      = {shreg[W-2:0], sdata_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= WAIT_LR;
            lr_prev   <= 1'b0;
            lr_primed <= 1'b0;
            chan      <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            l_hold    <= '0;
            left_ok   <= 1'b0;
            l_data    <= '0;
            r_data    <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (tick) begin
                lr_prev   <= lr_s;
                lr_primed <= 1'b1;
                case (state)
                    WAIT_LR: begin
                        if (lr_chg)
                            state <= SKIP;
                    end
                    // The tick that revealed the lrclk edge was the delay bit; this one carries the MSB.
                    SKIP: begin
                        chan    <= lr_s;
                        shreg   <= word;
                        bit_cnt <= CNT_W'(1);
                        state   <= SHIFT;
                    end
                    SHIFT: begin
                        if (short_evt) begin
                            frame_err <= 1'b1;
                            left_ok   <= 1'b0;
                            state     <= SKIP;
                        end else begin
                            shreg   <= word;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (last_bit) begin
                                // An exactly-W-bit slot puts the LSB on the next edge's delay bit.
                                state <= lr_chg ? SKIP : HOLD;
                                if (!chan) begin
                                    l_hold  <= word;
                                    left_ok <= 1'b1;
                                end else if (left_ok) begin
                                    l_data  <= l_hold;
                                    r_data  <= word;
                                    valid   <= 1'b1;
                                    left_ok <= 1'b0;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (lr_chg)
                            state <= SKIP;
                    end
                    default: state <= WAIT_LR;
                endcase
            end
        end
    end

`ifdef I2S_RX_ERR_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_cnt <= '0;
        else if (short_evt)
            err_cnt <= sat_inc(err_cnt);
    end
`endif

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Directed bench for i2s_adc_rx: bclk = clk/32, I2S framing with one delay bit
// per slot, immediate-assertion checks and one summary line.
module tb_i2s_adc_rx;

    localparam int W = 24;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ac_bclk = 1'b0;
    logic          ac_lrclk = 1'b1;
    logic          ac_adc_sdata = 1'b0;
    logic [W-1:0]  l_data;
    logic [W-1:0]  r_data;
    logic          valid;
    logic          frame_err;
`ifdef I2S_RX_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int ferr_base;
    int vld_base;

    i2s_adc_rx #(.W(W), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ac_bclk      (ac_bclk),
        .ac_lrclk     (ac_lrclk),
        .ac_adc_sdata (ac_adc_sdata),
        .l_data       (l_data),
        .r_data       (r_data),
        .valid        (valid),
`ifdef I2S_RX_ERR_CNT_EN
        .err_cnt      (err_cnt),
`endif
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) vld_cnt++;
        if (frame_err) ferr_cnt++;
        if (valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // Data and lrclk change while bclk is low; the receiver samples on the rise.
    task automatic send_bit(input logic lr, input logic d);
        @(negedge clk);
        ac_bclk      = 1'b0;
        ac_lrclk     = lr;
        ac_adc_sdata = d;
        repeat (16) @(negedge clk);
        ac_bclk = 1'b1;
        repeat (15) @(negedge clk);
    endtask

    task automatic send_word(input logic lr, input logic [W-1:0] w, input int pad);
        send_bit(lr, 1'b1);
        for (int i = W - 1; i >= 0; i--) send_bit(lr, w[i]);
        for (int i = 0; i < pad; i++) send_bit(lr, 1'b1);
    endtask

    task automatic send_short(input logic lr, input logic [W-1:0] w, input int nbits);
        send_bit(lr, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(lr, w[W-1-i]);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_l_data", l_data, 0);
        chk("rst_r_data", r_data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_frame_err", frame_err, 0);
`ifdef I2S_RX_ERR_CNT_EN
        chk("rst_err_cnt", err_cnt, 0);
`endif
        reset_n = 1'b1;

        // Clean frame, 25-bit slots
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        send_word(1'b0, 24'h123456, 0);
        send_word(1'b1, 24'hA5A5A5, 0);
        repeat (40) @(negedge clk);
        chk("clean_vld_cnt", vld_cnt, 1);
        chk("clean_l", l_data, 24'h123456);
        chk("clean_r", r_data, 24'hA5A5A5);
        chk("clean_ferr", ferr_cnt, 0);

        // 32-bit slots with junk tail
        send_word(1'b0, 24'h800001, 7);
        send_word(1'b1, 24'h7FFFFE, 7);
        chk("slot32_vld_cnt", vld_cnt, 2);
        chk("slot32_l", l_data, 24'h800001);
        chk("slot32_r", r_data, 24'h7FFFFE);
        chk("slot32_ferr", ferr_cnt, 0);

        // Short left word after 20 bits
        send_short(1'b0, 24'hFFFFFF, 20);
        send_word(1'b1, 24'h111111, 7);
        chk("short_ferr", ferr_cnt, 1);
        chk("short_no_vld", vld_cnt, 2);
        chk("short_l_hold", l_data, 24'h800001);
        chk("short_r_hold", r_data, 24'h7FFFFE);
        send_word(1'b0, 24'h0F0F0F, 7);
        send_word(1'b1, 24'hF0F0F0, 7);
        chk("recover_vld_cnt", vld_cnt, 3);
        chk("recover_l", l_data, 24'h0F0F0F);
        chk("recover_r", r_data, 24'hF0F0F0);

        // Start mid right slot after reset
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1'b1, i[0]);
        send_word(1'b0, 24'hABCDEF, 3);
        chk("mid_no_vld_yet", vld_cnt, 3);
        send_word(1'b1, 24'h135790, 3);
        chk("mid_vld_cnt", vld_cnt, 4);
        chk("mid_l", l_data, 24'hABCDEF);
        chk("mid_r", r_data, 24'h135790);

        // Reset for 3 cycles at bit 12 of a right word
        send_word(1'b0, 24'h2468AC, 7);
        send_short(1'b1, 24'hFEDCBA, 12);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_l", l_data, 0);
        chk("midrst_r", r_data, 0);
        chk("midrst_valid", valid, 0);
        reset_n = 1'b1;
        for (int i = 11; i >= 0; i--) send_bit(1'b1, i[0]);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b1);
        chk("midrst_no_vld", vld_cnt, 4);
        send_word(1'b0, 24'h654321, 7);
        send_word(1'b1, 24'h0ABCDE, 7);
        chk("midrst_vld_cnt", vld_cnt, 5);
        chk("midrst_new_l", l_data, 24'h654321);
        chk("midrst_new_r", r_data, 24'h0ABCDE);

        // Three consecutive short words
        ferr_base = ferr_cnt;
        vld_base  = vld_cnt;
        send_short(1'b0, 24'h123123, 10);
        send_short(1'b1, 24'h456456, 10);
        send_short(1'b0, 24'h789789, 10);
        send_word(1'b1, 24'h3C3C3C, 7);
        chk("multi_ferr", ferr_cnt - ferr_base, 3);
        chk("multi_no_vld", vld_cnt - vld_base, 0);
        chk("multi_l_hold", l_data, 24'h654321);
`ifdef I2S_RX_ERR_CNT_EN
        chk("err_cnt_3", err_cnt, 16'd3);
        @(negedge clk);
        force dut.err_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.err_cnt;
        send_short(1'b0, 24'h000000, 10);
        send_word(1'b1, 24'h3C3C3C, 7);
        chk("err_cnt_sat", err_cnt, 16'hFFFF);
`endif

        chk("valid_ferr_exclusive", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
